// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Load/store data memory for the ARM datapath with a request/response
//   handshake. Each accepted request returns exactly one response pulse
//   LATENCY cycles after acceptance. Storage is little-endian, organised as
//   DEPTH_WORDS 64-bit words. Sub-dword loads can be zero- or sign-extended.
//   Misaligned accesses leave storage untouched and report misaligned=1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears storage too)
//   address    byte address; upper bits beyond the storage size are ignored
//   writeData  store data, right-aligned
//   memWrite   store request (wins over memRead when both are set)
//   memRead    load request
//   size       00 byte, 01 half, 10 word, 11 dword
//   signExt    sign-extend sub-dword loads when 1
//   reqReady   request is accepted at the next edge when high
//   respValid  one-cycle response pulse
//   readData   load result, zero unless respValid
//   misaligned alignment error flag, zero unless respValid
module data_memory_sized #(
  parameter int BITSIZE     = 64,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] address,
  input  logic [BITSIZE-1:0] writeData,
  input  logic               memWrite,
  input  logic               memRead,
  input  logic [1:0]         size,
  input  logic               signExt,
  output logic               reqReady,
  output logic               respValid,
  output logic [BITSIZE-1:0] readData,
  output logic               misaligned
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Lane mask for an access of the given size, right-aligned.
  function automatic logic [BITSIZE-1:0] size_mask(input logic [1:0] sz);
    logic [BITSIZE-1:0] m;
    m = '1;
    case (sz)
      2'b00:   m = BITSIZE'(8'hFF);
      2'b01:   m = BITSIZE'(16'hFFFF);
      2'b10:   m = BITSIZE'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] lane);
    logic mis;
    case (sz)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane[0];
      2'b10:   mis = |lane[1:0];
      default: mis = |lane;
    endcase
    return mis;
  endfunction

  // Shift the addressed lanes down to bit 0 and extend. A dword has no
  // sign bit to replicate, so signExt has no effect there.
  function automatic logic [BITSIZE-1:0] load_extract(input logic [BITSIZE-1:0] word,
                                                      input logic [2:0] lane,
                                                      input logic [1:0] sz,
                                                      input logic sext);
    logic [BITSIZE-1:0] sh;
    logic [BITSIZE-1:0] m;
    logic               msb;
    sh = word >> {lane, 3'b000};
    m  = size_mask(sz);
    case (sz)
      2'b00:   msb = sh[7];
      2'b01:   msb = sh[15];
      2'b10:   msb = sh[31];
      default: msb = 1'b0;
    endcase
    return (sh & m) | ((sext && msb) ? ~m : '0);
  endfunction

  // Replace only the addressed lanes; callers guarantee alignment so the
  // shifted mask never runs past the top of the word.
  function automatic logic [BITSIZE-1:0] store_merge(input logic [BITSIZE-1:0] old,
                                                     input logic [BITSIZE-1:0] wd,
                                                     input logic [2:0] lane,
                                                     input logic [1:0] sz);
    logic [BITSIZE-1:0] m;
    m = size_mask(sz) << {lane, 3'b000};
    return (old & ~m) | ((wd << {lane, 3'b000}) & m);
  endfunction

  logic [BITSIZE-1:0] mem_q [DEPTH_WORDS];
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BITSIZE-1:0] pend_data_q;
  logic               pend_mis_q;
  logic               resp_valid_q;
  logic [BITSIZE-1:0] read_data_q;
  logic               mis_q;

  logic [IDX_W-1:0]   word_idx;
  logic [2:0]         lane;
  logic               accept;
  logic               acc_mis;
  logic [BITSIZE-1:0] pend_data_d;
  logic               unused_addr_bits;

  assign word_idx         = address[IDX_W+2:3];
  assign lane             = address[2:0];
  assign unused_addr_bits = ^address[BITSIZE-1:IDX_W+3];
  assign accept           = (state_q == IDLE) && (memRead || memWrite);
  assign acc_mis          = is_misaligned(size, lane);
  // Stores and misaligned accesses answer with zero data.
  assign pend_data_d      = (memWrite || acc_mis) ? '0
                          : load_extract(mem_q[word_idx], lane, size, signExt);

  // Stores commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (accept && memWrite && !acc_mis) begin
      mem_q[word_idx] <= store_merge(mem_q[word_idx], writeData, lane, size);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_mis_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      read_data_q  <= '0;
      mis_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= BUSY;
            cnt_q       <= CNT_W'(1);
            pend_data_q <= pend_data_d;
            pend_mis_q  <= acc_mis;
            // With a single-cycle latency the response is due immediately.
            if (LATENCY == 1) begin
              resp_valid_q <= 1'b1;
              read_data_q  <= pend_data_d;
              mis_q        <= acc_mis;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(LATENCY)) begin
            // Response cycle ends; no acceptance here by design.
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            read_data_q  <= '0;
            mis_q        <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(LATENCY)) begin
              resp_valid_q <= 1'b1;
              read_data_q  <= pend_data_q;
              mis_q        <= pend_mis_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady   = (state_q == IDLE);
  assign respValid  = resp_valid_q;
  assign readData   = read_data_q;
  assign misaligned = mis_q;

endmodule
